// File: rtl/clk_tick_gen_if.sv
// ---------------------------------------------------------------------------
// clk_tick_gen_if
// Control and output bundle of the clock-enable generator.
//   en        global run (0 freezes all channels)
//   sync_rst  synchronous restart of every channel phase
//   ch_en     per-channel run enable
//   ld        per-channel divisor load strobe
//   ld_val    divisor value shared by all load strobes
//   tick      one-cycle clock-enable pulse per channel period
//   sq        per-channel square wave
//   div_act   active divisors, channel 0 in the LSBs
// master: drives the controls and reads the outputs.
// slave:  the generator itself.
// ---------------------------------------------------------------------------
interface clk_tick_gen_if #(
    parameter int NCH   = 3,
    parameter int CNT_W = 24
);
    logic                   en;
    logic                   sync_rst;
    logic [NCH-1:0]         ch_en;
    logic [NCH-1:0]         ld;
    logic [CNT_W-1:0]       ld_val;
    logic [NCH-1:0]         tick;
    logic [NCH-1:0]         sq;
    logic [NCH*CNT_W-1:0]   div_act;

    modport master (
        output en, sync_rst, ch_en, ld, ld_val,
        input  tick, sq, div_act
    );

    modport slave (
        input  en, sync_rst, ch_en, ld, ld_val,
        output tick, sq, div_act
    );
endinterface

// File: rtl/clk_tick_gen.sv
// ---------------------------------------------------------------------------
// clk_tick_gen
// Multi-channel programmable clock-enable generator. Every channel runs an
// independent modulo-div counter and produces a registered one-cycle tick at
// the end of each period plus a registered square wave (low for the first
// div/2 counts, high for the rest). Divisors can be reloaded at runtime; a
// new divisor only takes effect at a period boundary (wrap) or on sync_rst,
// so no runt periods are produced.
// Ports:
//   mclk  system clock
//   clr   asynchronous active-high reset
//   bus   clk_tick_gen_if.slave (en, sync_rst, ch_en, ld, ld_val in;
//         tick, sq, div_act out)
// ---------------------------------------------------------------------------
module clk_tick_gen #(
    parameter int                   NCH   = 3,
    parameter int                   CNT_W = 24,
    parameter logic [NCH*CNT_W-1:0] DIV   = {24'd1666667, 24'd524288, 24'd4}
) (
    input  logic            mclk,
    input  logic            clr,
    clk_tick_gen_if.slave   bus
);

    if (NCH < 1 || NCH > 8) begin : g_bad_nch
        $fatal(1, "clk_tick_gen: NCH must be in 1..8");
    end

    for (genvar g = 0; g < NCH; g++) begin : g_div_chk
        if (DIV[g*CNT_W +: CNT_W] == '0) begin : g_bad_div
            $fatal(1, "clk_tick_gen: reset divisor of channel %0d is zero", g);
        end
    end

    logic [NCH-1:0][CNT_W-1:0] cnt_q,  cnt_d;
    logic [NCH-1:0][CNT_W-1:0] div_q,  div_d;
    logic [NCH-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [NCH-1:0]            pend_v_q, pend_v_d;
    logic [NCH-1:0]            tick_q, tick_d;
    logic [NCH-1:0]            sq_q,   sq_d;

    logic [NCH-1:0]            adv;
    logic [NCH-1:0]            wrap;
    logic [NCH-1:0]            ld_ok;

    always_comb begin
        cnt_d    = cnt_q;
        div_d    = div_q;
        pend_d   = pend_q;
        pend_v_d = pend_v_q;
        tick_d   = '0;
        sq_d     = sq_q;
        adv      = '0;
        wrap     = '0;
        ld_ok    = '0;

        for (int i = 0; i < NCH; i++) begin
            adv[i]   = bus.en & bus.ch_en[i];
            wrap[i]  = adv[i] && (cnt_q[i] == div_q[i] - CNT_W'(1));
            // A zero divisor would never wrap, so such loads are dropped.
            ld_ok[i] = bus.ld[i] && (bus.ld_val != '0);

            // Same-cycle load counts as pending, so it can switch at this wrap.
            if (ld_ok[i]) begin
                pend_d[i]   = bus.ld_val;
                pend_v_d[i] = 1'b1;
            end

            // Divisor swaps only at a period boundary: counter is back at 0.
            if ((bus.sync_rst || wrap[i]) && pend_v_d[i]) begin
                div_d[i]    = pend_d[i];
                pend_v_d[i] = 1'b0;
            end

            if (bus.sync_rst) begin
                cnt_d[i] = '0;
                sq_d[i]  = 1'b0;
            end else if (adv[i]) begin
                cnt_d[i]  = wrap[i] ? '0 : cnt_q[i] + CNT_W'(1);
                tick_d[i] = wrap[i];
                // Compare against the divisor governing the new count.
                sq_d[i]   = (cnt_d[i] >= (div_d[i] >> 1));
            end
        end
    end

    always_ff @(posedge mclk or posedge clr) begin
        if (clr) begin
            cnt_q    <= '0;
            div_q    <= DIV;
            pend_q   <= '0;
            pend_v_q <= '0;
            tick_q   <= '0;
            sq_q     <= '0;
        end else begin
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            tick_q   <= tick_d;
            sq_q     <= sq_d;
        end
    end

    assign bus.tick    = tick_q;
    assign bus.sq      = sq_q;
    assign bus.div_act = div_q;

endmodule

// File: tb/tb_clk_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_clk_tick_gen
// Self-checking bench for clk_tick_gen: a table of vectors from reset, hand
// sequences for reload, freeze, sync restart and asynchronous clear, then
// randomized traffic against a period/phase reference model.
// ---------------------------------------------------------------------------
module tb_clk_tick_gen;

    localparam int NCH   = 3;
    localparam int CNT_W = 24;
    localparam logic [NCH*CNT_W-1:0] TB_DIV = {24'd5, 24'd3, 24'd4};

    logic mclk;
    logic clr;

    clk_tick_gen_if #(.NCH(NCH), .CNT_W(CNT_W)) bus ();

    clk_tick_gen #(.NCH(NCH), .CNT_W(CNT_W), .DIV(TB_DIV)) dut (
        .mclk (mclk),
        .clr  (clr),
        .bus  (bus)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: phase = advances completed in the current period.
    int         m_ph   [NCH];
    int         m_div  [NCH];
    int         m_pend [NCH];
    bit         m_pv   [NCH];
    logic [NCH-1:0] m_tick;
    logic [NCH-1:0] m_sq;

    typedef struct {
        logic           en;
        logic           sync_rst;
        logic [NCH-1:0] ch_en;
        logic [NCH-1:0] ld;
        logic [CNT_W-1:0] ld_val;
        logic [NCH-1:0] exp_tick;
        logic [NCH-1:0] exp_sq;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // High for the last ceil(d/2) positions of a d-long period.
    function automatic logic sq_of(input int p, input int d);
        return p >= (d - (d + 1) / 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_ph[i]   = 0;
            m_div[i]  = int'(TB_DIV[i*CNT_W +: CNT_W]);
            m_pend[i] = 0;
            m_pv[i]   = 1'b0;
        end
        m_tick = '0;
        m_sq   = '0;
    endtask

    task automatic model_step();
        for (int i = 0; i < NCH; i++) begin
            if (bus.ld[i] && bus.ld_val != 0) begin
                m_pend[i] = int'(bus.ld_val);
                m_pv[i]   = 1'b1;
            end
            m_tick[i] = 1'b0;
            if (bus.sync_rst) begin
                if (m_pv[i]) begin
                    m_div[i] = m_pend[i];
                    m_pv[i]  = 1'b0;
                end
                m_ph[i] = 0;
                m_sq[i] = 1'b0;
            end else if (bus.en && bus.ch_en[i]) begin
                m_ph[i]++;
                if (m_ph[i] >= m_div[i]) begin
                    m_ph[i]   = 0;
                    m_tick[i] = 1'b1;
                    if (m_pv[i]) begin
                        m_div[i] = m_pend[i];
                        m_pv[i]  = 1'b0;
                    end
                end
                m_sq[i] = sq_of(m_ph[i], m_div[i]);
            end
        end
    endtask

    function automatic logic [71:0] model_div();
        logic [71:0] v;
        v = '0;
        for (int i = 0; i < NCH; i++) v[i*CNT_W +: CNT_W] = CNT_W'(m_div[i]);
        return v;
    endfunction

    task automatic cycle();
        model_step();
        @(posedge mclk);
        @(negedge mclk);
        check("tick", 72'(bus.tick), 72'(m_tick));
        check("sq", 72'(bus.sq), 72'(m_sq));
        check("div_act", 72'(bus.div_act), model_div());
    endtask

    task automatic wait_tick(input int ch, input int lim, output int n);
        n = 0;
        do begin
            cycle();
            n++;
        end while (!bus.tick[ch] && n < lim);
        check("tick_seen", 72'(bus.tick[ch]), 72'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic sq1;

        // ch0 d=4, ch1 d=3, ch2 d=5 from reset; vectors are {ch2,ch1,ch0}.
        tbl[0] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b000, 3'b010};
        tbl[1] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b000, 3'b111};
        tbl[2] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b010, 3'b101};
        tbl[3] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b001, 3'b110};
        tbl[4] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b100, 3'b010};
        tbl[5] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b010, 3'b001};
        tbl[6] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b000, 3'b111};
        tbl[7] = '{1'b1, 1'b0, 3'b111, 3'b000, 24'd0, 3'b001, 3'b110};

        bus.en       = 1'b0;
        bus.sync_rst = 1'b0;
        bus.ch_en    = '0;
        bus.ld       = '0;
        bus.ld_val   = '0;
        clr          = 1'b1;
        model_reset();
        repeat (2) @(negedge mclk);
        check("rst_tick", 72'(bus.tick), 72'd0);
        check("rst_sq", 72'(bus.sq), 72'd0);
        check("rst_div", 72'(bus.div_act), 72'(TB_DIV));
        clr = 1'b0;

        // Free run from reset.
        for (int k = 0; k < 8; k++) begin
            bus.en       = tbl[k].en;
            bus.sync_rst = tbl[k].sync_rst;
            bus.ch_en    = tbl[k].ch_en;
            bus.ld       = tbl[k].ld;
            bus.ld_val   = tbl[k].ld_val;
            cycle();
            check("tbl_tick", 72'(bus.tick), 72'(tbl[k].exp_tick));
            check("tbl_sq", 72'(bus.sq), 72'(tbl[k].exp_sq));
        end

        // Reload ch0 to 6 at cnt=1: current period keeps 4, next uses 6.
        cycle();
        bus.ld     = 3'b001;
        bus.ld_val = 24'd6;
        cycle();
        bus.ld     = '0;
        bus.ld_val = '0;
        check("ld_wait_div", 72'(bus.div_act[CNT_W-1:0]), 72'd4);
        wait_tick(0, 10, n);
        check("ld_old_gap", 72'(n), 72'd2);
        check("ld_new_div", 72'(bus.div_act[CNT_W-1:0]), 72'd6);
        wait_tick(0, 12, n);
        check("ld_new_gap", 72'(n), 72'd6);

        // Freeze ch1 for 10 cycles.
        cycle();
        bus.ch_en = 3'b101;
        sq1 = bus.sq[1];
        for (int k = 0; k < 10; k++) begin
            cycle();
            check("frz_tick", 72'(bus.tick[1]), 72'd0);
            check("frz_sq", 72'(bus.sq[1]), 72'(sq1));
        end
        bus.ch_en = 3'b111;
        repeat (7) cycle();

        // Pending loads then sync restart: all channels align on div 4.
        bus.ld     = 3'b111;
        bus.ld_val = 24'd4;
        cycle();
        bus.ld       = '0;
        bus.ld_val   = '0;
        bus.sync_rst = 1'b1;
        cycle();
        bus.sync_rst = 1'b0;
        check("srst_tick", 72'(bus.tick), 72'd0);
        check("srst_sq", 72'(bus.sq), 72'd0);
        check("srst_div", 72'(bus.div_act), {24'd4, 24'd4, 24'd4});
        repeat (3) begin
            cycle();
            check("srst_notick", 72'(bus.tick), 72'd0);
        end
        cycle();
        check("srst_together", 72'(bus.tick), 72'b111);

        // Asynchronous clear between edges.
        repeat (2) cycle();
        model_step();
        @(posedge mclk);
        #2;
        clr = 1'b1;
        model_reset();
        #1;
        check("clr_tick", 72'(bus.tick), 72'd0);
        check("clr_sq", 72'(bus.sq), 72'd0);
        check("clr_div", 72'(bus.div_act), 72'(TB_DIV));
        @(negedge mclk);
        clr = 1'b0;

        // Zero load value is ignored.
        bus.ld     = 3'b111;
        bus.ld_val = 24'd0;
        cycle();
        bus.ld = '0;
        repeat (6) cycle();
        check("ld0_div", 72'(bus.div_act), 72'(TB_DIV));

        // Divisor 1: tick every cycle, sq constantly high.
        bus.ld     = 3'b001;
        bus.ld_val = 24'd1;
        cycle();
        bus.ld     = '0;
        bus.ld_val = '0;
        wait_tick(0, 10, n);
        repeat (3) begin
            cycle();
            check("div1_tick", 72'(bus.tick[0]), 72'd1);
            check("div1_sq", 72'(bus.sq[0]), 72'd1);
        end

        // Randomized traffic against the model.
        for (int k = 0; k < 400; k++) begin
            bus.en       = ($urandom_range(0, 9) != 0);
            bus.sync_rst = ($urandom_range(0, 39) == 0);
            bus.ch_en    = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            bus.ld       = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'b000;
            bus.ld_val   = 24'($urandom_range(0, 7));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
